// File: rtl/mips32_prog_loader.sv
// Byte-stream program loader for the MIPS32 core: packs big-endian bytes
// into words, writes instruction memory, verifies an XOR checksum, releases
// the core and reports when it halts.
//
// Ports:
//   clk1, rst_n          clock, async active-low reset
//   start                begin a load (IDLE/DONE/ERROR only)
//   in_valid/in_ready    byte handshake; in_data big-endian, in_last ends stream
//   mem_we/addr/wdata    registered instruction memory write port
//   core_halted          core HALTED flag
//   core_rst_n           active-low reset to the core
//   busy/done/err        status (LOAD|CHECK / DONE / ERROR)
//   word_count           payload words written in the current/last load
module mips32_prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              core_halted,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ADDR_W:0] CAP    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] WC_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state;
    state_t          nstate;
    logic [23:0]     asm_q;
    logic [1:0]      bidx;
    logic [31:0]     pend;
    logic            pend_v;
    logic [31:0]     csum;
    logic [ADDR_W:0] wc;
    logic            pass_q;

    logic            xfer;
    logic            wdone;
    logic            ovf;
    logic            load_go;
    logic [31:0]     word;
    logic [31:0]     csum_all;

    assign xfer     = in_valid && in_ready;
    assign word     = {asm_q, in_data};
    assign wdone    = xfer && (bidx == 2'd3);
    // A completed word with a pending one and a full memory cannot be stored.
    assign ovf      = pend_v && (wc == CAP);
    assign load_go  = start && ((state == S_IDLE) ||
                                (state == S_DONE) ||
                                (state == S_ERROR));
    // Checksum including the pending word flushed alongside the last word.
    assign csum_all = pend_v ? (csum ^ pend) : csum;

    assign word_count = wc;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE: begin
                if (start) nstate = S_LOAD;
            end
            S_LOAD: begin
                if (xfer && in_last) begin
                    if (bidx != 2'd3) nstate = S_ERROR;
                    else if (ovf)     nstate = S_ERROR;
                    else              nstate = S_CHECK;
                end else if (wdone && ovf) begin
                    nstate = S_ERROR;
                end
            end
            S_CHECK: begin
                nstate = pass_q ? S_RUN : S_ERROR;
            end
            S_RUN: begin
                if (core_halted) nstate = S_DONE;
            end
            S_DONE, S_ERROR: begin
                if (start) nstate = S_LOAD;
            end
            default: nstate = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        core_rst_n = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        unique case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_CHECK: busy = 1'b1;
            S_RUN:   core_rst_n = 1'b1;
            S_DONE: begin
                core_rst_n = 1'b1;
                done       = 1'b1;
            end
            S_ERROR: err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            asm_q     <= '0;
            bidx      <= '0;
            pend      <= '0;
            pend_v    <= 1'b0;
            csum      <= '0;
            wc        <= '0;
            pass_q    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (load_go) begin
                bidx   <= '0;
                wc     <= '0;
                pend_v <= 1'b0;
                csum   <= '0;
            end else if (xfer) begin
                asm_q <= word[23:0];
                bidx  <= bidx + 2'd1;
                if (wdone && !ovf) begin
                    if (pend_v) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wc[ADDR_W-1:0];
                        mem_wdata <= pend;
                        csum      <= csum ^ pend;
                        wc        <= wc + WC_ONE;
                    end
                    pend   <= word;
                    pend_v <= 1'b1;
                    if (in_last) pass_q <= (word == csum_all);
                end
            end
        end
    end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Self-checking bench for mips32_prog_loader: directed and randomized
// loads against a word-list reference model, plus a small-memory instance.
module tb_mips32_prog_loader;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        core_halted;

    logic        in_ready1, mem_we1, core_rst_n1, busy1, done1, err1;
    logic [9:0]  mem_addr1;
    logic [31:0] mem_wdata1;
    logic [10:0] word_count1;

    logic        in_ready2, mem_we2, core_rst_n2, busy2, done2, err2;
    logic [1:0]  mem_addr2;
    logic [31:0] mem_wdata2;
    logic [2:0]  word_count2;

    int checks = 0;
    int errors = 0;

    int          qa1[$];
    logic [31:0] qd1[$];
    int          qa2[$];
    logic [31:0] qd2[$];
    logic [31:0] pay[$];

    always #5 clk1 = ~clk1;

    mips32_prog_loader #(.ADDR_W(10)) dut1 (
        .clk1(clk1), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .core_halted(core_halted),
        .core_rst_n(core_rst_n1), .busy(busy1), .done(done1),
        .err(err1), .word_count(word_count1)
    );

    mips32_prog_loader #(.ADDR_W(2)) dut2 (
        .clk1(clk1), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .core_halted(core_halted),
        .core_rst_n(core_rst_n2), .busy(busy2), .done(done2),
        .err(err2), .word_count(word_count2)
    );

    always @(negedge clk1) begin
        if (mem_we1) begin
            qa1.push_back(int'(mem_addr1));
            qd1.push_back(mem_wdata1);
        end
        if (mem_we2) begin
            qa2.push_back(int'(mem_addr2));
            qd2.push_back(mem_wdata2);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] xor_all();
        logic [31:0] x = '0;
        foreach (pay[i]) x ^= pay[i];
        return x;
    endfunction

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last,
                             input bit gaps, input bit use2);
        bit ok = 1'b0;
        if (gaps) begin
            for (int g = 0; g < 3; g++) begin
                if ($urandom_range(0, 1) == 0) break;
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        for (int t = 0; t < 50; t++) begin
            if (use2 ? in_ready2 : in_ready1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("rdy_timeout", 64'(ok), 64'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit last,
                             input bit gaps, input bit use2);
        for (int i = 0; i < 4; i++)
            send_byte(w[31-8*i -: 8], last && (i == 3), gaps, use2);
    endtask

    task automatic cmp_writes1(input string tag, input int n);
        chk({tag, "_nwr"}, 64'(qa1.size()), 64'(n));
        for (int i = 0; i < n && i < qa1.size(); i++) begin
            chk({tag, "_addr"}, 64'(qa1[i]), 64'(i));
            chk({tag, "_data"}, 64'(qd1[i]), 64'(pay[i]));
        end
    endtask

    // Full load on the large instance; expectations come from the word list.
    task automatic run_load(input logic [31:0] ck, input bit gaps,
                            input bit poke, input string tag);
        int  n    = pay.size();
        bit  pass = (ck == xor_all());
        qa1.delete(); qd1.delete(); qa2.delete(); qd2.delete();
        pulse_start();
        chk({tag, "_busy"}, 64'(busy1), 64'd1);
        chk({tag, "_rdy"}, 64'(in_ready1), 64'd1);
        chk({tag, "_err0"}, 64'(err1), 64'd0);
        chk({tag, "_wc0"}, 64'(word_count1), 64'd0);
        for (int i = 0; i < n; i++) begin
            send_word(pay[i], 1'b0, gaps, 1'b0);
            if (poke && i == 3) pulse_start();
        end
        send_word(ck, 1'b1, gaps, 1'b0);
        chk({tag, "_chk_busy"}, 64'(busy1), 64'd1);
        chk({tag, "_chk_core"}, 64'(core_rst_n1), 64'd0);
        chk({tag, "_chk_we"}, 64'(mem_we1), 64'(n > 0));
        if (n > 0) begin
            chk({tag, "_chk_addr"}, 64'(mem_addr1), 64'(n - 1));
            chk({tag, "_chk_data"}, 64'(mem_wdata1), 64'(pay[n-1]));
        end
        tick();
        chk({tag, "_wc"}, 64'(word_count1), 64'(n));
        chk({tag, "_core"}, 64'(core_rst_n1), 64'(pass));
        chk({tag, "_err"}, 64'(err1), 64'(!pass));
        chk({tag, "_busy1"}, 64'(busy1), 64'd0);
        cmp_writes1(tag, n);
        if (pass) begin
            for (int i = 0; i < 3; i++) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                tick();
                chk({tag, "_run_rdy"}, 64'(in_ready1), 64'd0);
                chk({tag, "_run_we"}, 64'(mem_we1), 64'd0);
            end
            in_valid = 1'b0;
            chk({tag, "_run_wc"}, 64'(word_count1), 64'(n));
            chk({tag, "_run_done"}, 64'(done1), 64'd0);
            core_halted = 1'b1;
            tick();
            core_halted = 1'b0;
            chk({tag, "_done"}, 64'(done1), 64'd1);
            chk({tag, "_done_core"}, 64'(core_rst_n1), 64'd1);
        end
    endtask

    initial begin
        logic [31:0] prog[9];
        logic [31:0] ck;
        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                 32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                 32'hfc000000};

        rst_n       = 1'b0;
        start       = 1'b0;
        in_valid    = 1'b1;
        in_data     = 8'h5a;
        in_last     = 1'b0;
        core_halted = 1'b0;
        #3;
        chk("rst_rdy", 64'(in_ready1), 64'd0);
        chk("rst_we", 64'(mem_we1), 64'd0);
        chk("rst_addr", 64'(mem_addr1), 64'd0);
        chk("rst_wdata", 64'(mem_wdata1), 64'd0);
        chk("rst_core", 64'(core_rst_n1), 64'd0);
        chk("rst_status", 64'({busy1, done1, err1}), 64'd0);
        chk("rst_wc", 64'(word_count1), 64'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk1);
        #1;
        rst_n = 1'b1;
        tick();
        chk("idle_rdy", 64'(in_ready1), 64'd0);

        pay.delete();
        foreach (prog[i]) pay.push_back(prog[i]);
        run_load(32'hd8467007, 1'b0, 1'b0, "good");
        run_load(32'hd8467006, 1'b0, 1'b0, "badck");

        qa1.delete(); qd1.delete();
        pulse_start();
        chk("short_restart", 64'({busy1, err1, core_rst_n1}), 64'b100);
        send_word(32'h2801000a, 1'b0, 1'b0, 1'b0);
        send_byte(8'h28, 1'b0, 1'b0, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0, 1'b0);
        chk("short_err", 64'(err1), 64'd1);
        chk("short_rdy", 64'(in_ready1), 64'd0);
        chk("short_we", 64'(mem_we1), 64'd0);
        chk("short_wc", 64'(word_count1), 64'd0);
        tick();
        chk("short_nwr", 64'(qa1.size()), 64'd0);

        run_load(32'hd8467007, 1'b1, 1'b1, "gaps");

        pay.delete();
        for (int i = 0; i < 5; i++) pay.push_back($urandom);
        ck = xor_all();
        qa1.delete(); qd1.delete(); qa2.delete(); qd2.delete();
        pulse_start();
        chk("ovf_busy", 64'(busy2), 64'd1);
        for (int i = 0; i < 5; i++) send_word(pay[i], 1'b0, 1'b1, 1'b1);
        send_byte(ck[31:24], 1'b0, 1'b0, 1'b1);
        send_byte(ck[23:16], 1'b0, 1'b0, 1'b1);
        send_byte(ck[15:8], 1'b0, 1'b0, 1'b1);
        chk("ovf_err_pre", 64'(err2), 64'd0);
        send_byte(ck[7:0], 1'b1, 1'b0, 1'b1);
        chk("ovf_err", 64'(err2), 64'd1);
        chk("ovf_we", 64'(mem_we2), 64'd0);
        chk("ovf_wc", 64'(word_count2), 64'd4);
        tick();
        chk("ovf_nwr", 64'(qa2.size()), 64'd4);
        for (int i = 0; i < 4 && i < qa2.size(); i++) begin
            chk("ovf_addr", 64'(qa2[i]), 64'(i));
            chk("ovf_data", 64'(qd2[i]), 64'(pay[i]));
        end
        chk("ovf_core", 64'(core_rst_n2), 64'd0);
        chk("ovf_big_core", 64'(core_rst_n1), 64'd1);
        core_halted = 1'b1;
        tick();
        core_halted = 1'b0;
        chk("ovf_big_done", 64'(done1), 64'd1);

        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(0, 8);
            pay.delete();
            for (int i = 0; i < n; i++) pay.push_back($urandom);
            ck = xor_all();
            if ($urandom_range(0, 1) == 1)
                ck ^= 32'h1 << $urandom_range(0, 31);
            run_load(ck, 1'b1, 1'b0, "rand");
        end

        pay.delete();
        for (int i = 0; i < 3; i++) pay.push_back($urandom);
        pulse_start();
        for (int i = 0; i < 3; i++) send_word(pay[i], 1'b0, 1'b0, 1'b0);
        chk("mid_wc_pre", 64'(word_count1), 64'd2);
        #3;
        in_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("mid_rdy", 64'(in_ready1), 64'd0);
        chk("mid_status", 64'({busy1, done1, err1}), 64'd0);
        chk("mid_core", 64'(core_rst_n1), 64'd0);
        chk("mid_wc", 64'(word_count1), 64'd0);
        chk("mid_we", 64'(mem_we1), 64'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_idle", 64'({busy1, in_ready1}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mips32_prog_loader.md
# mips32_prog_loader

Byte-stream program loader that sits directly upstream of the pipelined MIPS32 core. It assembles big-endian bytes into 32-bit instruction words and writes them into the core's instruction memory from address 0 upward. It verifies a trailing XOR checksum, and only after a good load releases the core from reset. It then watches the core's halt flag and reports completion, replacing bench-side back-door memory preloading.

## Interface
- ADDR_W, 10: instruction memory word-address width; capacity is 2^ADDR_W payload words.
- clk1  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte; the first byte of each word is bits 31:24.
- in_last  input  1  marks the final byte of the stream, which is the last byte of the checksum word.
- in_ready  output  1  loader accepts a byte; a transfer occurs on an edge where in_valid && in_ready.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  write word address.
- mem_wdata  output  32  write data.
- core_halted  input  1  the core's HALTED flag.
- core_rst_n  output  1  active-low reset to the core; low holds the core.
- busy  output  1  high in LOAD or CHECK.
- done  output  1  high in DONE.
- err  output  1  high in ERROR.
- word_count  output  ADDR_W+1  number of payload words written in the current or last load.

## Operation
- States are IDLE, LOAD, CHECK, RUN, DONE and ERROR.
- IDLE:
  - start moves to LOAD.
  - On entry to LOAD, these are cleared: byte index, word_count, pending flag and running checksum.
- LOAD:
  - in_ready = 1 and core_rst_n = 0.
  - Bytes shift into a 32-bit assembly register, MSB first, with a 2-bit byte index.
- Word completion (the 4th byte) uses one-word buffering, because the checksum word is known only when in_last arrives:
  - If pending is valid, write the pending word at mem_addr = word_count, XOR it into the checksum, and increment word_count.
  - The new word becomes pending.
- in_last on the 4th byte:
  - The pending word, if any, is written.
  - The completed word is the checksum; it is compared with the checksum accumulated over all payload words, including the one just written.
  - State moves to CHECK, with the pass/fail result registered.
- in_last on bytes 1-3 goes to ERROR immediately; the partial word is discarded.
- Overflow: a word completes while pending is valid and word_count == 2^ADDR_W. This goes to ERROR, and no write is issued. It takes priority over the checksum compare.
- Zero-payload stream (checksum word only): passes iff the checksum word is 0.
- CHECK lasts exactly one cycle and carries the final write; it then moves to RUN on pass, ERROR on fail.
- RUN: core_rst_n = 1. core_halted = 1 moves to DONE.
- DONE: core_rst_n stays 1. ERROR: core_rst_n = 0.
- From DONE or ERROR, start restarts LOAD and pulls core_rst_n low.
- start in LOAD, CHECK or RUN is ignored.
- in_valid in states other than LOAD is ignored, since in_ready is 0.

## Timing
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, core_rst_n 0, busy 0, done 0, err 0, word_count 0.
- Reset mid-operation aborts immediately to IDLE and holds the core in reset. Memory contents are left as written.
- in_ready is decoded from the registered state; it has no combinational path from in_valid.
- mem_we, mem_addr and mem_wdata are registered and pulse high in the cycle after the accepting edge that triggered the write.
- Minimum 4 cycles per word; in_valid gaps stretch that arbitrarily without loss.
- in_last accept edge to CHECK: 1 cycle. The final mem_we is high during CHECK.
- core_rst_n rises on the edge leaving CHECK, so no write ever overlaps core release.
- core_halted sampled at edge N: done is high from edge N.
- Error detection to err high: 1 cycle.

## Test plan
- Reset: assert rst_n = 0 mid-cycle -> all outputs at reset values asynchronously; in_ready = 0 even with in_valid = 1.
- Good load:
  - Stimulus: stream 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000, then checksum d8467007 with in_last.
  - Response: 9 writes to addr 0-8 with matching data; word_count = 9; CHECK for one cycle, then core_rst_n = 1.
  - Then drive core_halted = 1 -> done = 1.
- Bad checksum: same stream with checksum d8467006 -> all 9 payload writes occur; err = 1; core_rst_n stays 0; start then restarts LOAD.
- Short last word: 2801000a, then two bytes with in_last on the second -> ERROR after 1 cycle; no write for the partial word.
- Backpressure/gaps: repeat the good load with in_valid toggled pseudo-randomly, start pulsed during LOAD, and in_valid pulsed during RUN -> identical writes and result; the extra start and the RUN-state bytes are ignored.
- Overflow, ADDR_W = 2: 5 payload words plus checksum -> writes to addr 0-3 only, then err = 1 when the checksum word completes; no 5th write.
